cbus_sram_responder: RTL and testbench
======================================

# cbus_sram_responder

- CBus responder backed by a synchronous-write, asynchronous-read word array.
- Terminates the single CBus port that leaves the arbiter, so initiators can be exercised end-to-end in simulation and on FPGA without an external memory controller.
- Serves single and incrementing-burst reads and byte-strobed writes.
- Inserts a configurable number of wait cycles before the first beat of every transaction.

## Interface

Parameters:

- `WORDS`, default 1024: number of 32-bit words; power of two, ≥ 16.
- `LATENCY`, default 2: idle cycles between request acceptance and the first data beat; 0..15.

Ports:

- `clk` input 1: clock; all state updates on the rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `req` input `cbus_req_t`: fields valid, is_write, size, addr[31:0], strobe[3:0], data[31:0], len (`mlen_t`, beats−1, so MLEN1=0 … MLEN16=15).
- `resp` output `cbus_resp_t`: fields ready, last, data[31:0].

## Operation

Word index is `addr[$clog2(WORDS)+1:2]`. Higher address bits and `addr[1:0]` are ignored, and `size` is ignored (byte selection is by strobe only).

FSM states:

- **IDLE**: `resp` = 0.
  - On an edge with `req.valid` = 1: capture the word index into `ptr`, `len` into `remain`, load `wait_cnt` with `LATENCY`.
  - Then go to WAIT if `LATENCY` > 0, else BURST.
- **WAIT**: `resp` = 0; `wait_cnt` decrements each edge; go to BURST on the edge where `wait_cnt` = 1.
- **BURST**:
  - `resp.ready` = 1 every cycle.
  - `resp.last` = (`remain` == 0).
  - `resp.data` = `mem[ptr]` (combinational read), driven on both reads and writes.
  - Each edge:
    - if `is_write`, byte lane k of `mem[ptr]` takes `req.data[8k+7:8k]` where `strobe[k]` = 1;
    - `ptr` increments modulo `WORDS`, so a burst wraps from the last word to word 0;
    - `remain` decrements.
  - On the edge with `last` = 1, go to IDLE.

Protocol rules:

- The initiator holds all request fields stable from acceptance until the `last` beat.
- Write data and strobe are sampled only on `ready` beats.
- The initiator drops `valid` in the cycle after `last`.
- If `valid` falls while in WAIT or BURST (illegal): return to IDLE at that edge and commit no write on that edge.
- Writes already committed earlier in the burst remain.

Memory:

- `mem` is not reset.
- Contents persist across resets.
- Read-after-write inside a burst sees the updated word on any later beat that addresses it.

## Timing

- Reset: asynchronous assertion forces IDLE and clears `ptr`, `remain` and `wait_cnt`, making `resp` = 0 immediately. Applies mid-burst: the in-flight transaction is abandoned.
- Latency: request valid at edge T0 (in IDLE), first `ready` beat in the cycle after edge T0+`LATENCY`, i.e. `LATENCY`+1 cycles after `valid` was first sampled.
- A burst of `len`+1 beats occupies exactly `len`+1 consecutive `ready` cycles; no gaps.
- Back-to-back: at the earliest, the next request is accepted one cycle after the `last` beat (at least one IDLE cycle between transactions).
- `resp` is a function of the registered state plus `mem` only; no combinational path from `req` to `resp.ready`/`resp.last`.

## Test plan

- **Reset**:
  - Stimulus: hold `resetn` low for 3 cycles, with `req.valid` high.
  - Required: `resp` = 0 throughout and during the first cycle after release; a fresh request after release is served normally.
- **Single write then read, `LATENCY`=2**:
  - Stimulus: write addr 0x10, data 0xDEADBEEF, strobe 0xF, MLEN1; then read addr 0x10, MLEN1.
  - Required: the write's `ready`=`last`=1 in the 3rd cycle after `valid` is first sampled; the read returns 0xDEADBEEF in its 3rd cycle.
- **Strobe**:
  - Stimulus: preload 0x11223344 at addr 0x20, write 0xAABBCCDD with strobe 0x5, then read addr 0x20.
  - Required: the read returns 0x11BB33DD.
- **16-beat burst with wrap, `WORDS`=1024**:
  - Stimulus: write words i=0..15 with data 0x100+i at addr 0xFF8 (word 1022) using MLEN16, then read back with MLEN16.
  - Required: 16 contiguous `ready` beats, `last` only on beat 16; words 1022, 1023, 0..13 are written; the read returns 0x100..0x10F in order.
- **`LATENCY`=0, back-to-back**:
  - Stimulus: two MLEN4 reads issued immediately one after the other.
  - Required: first beat in the cycle after `valid` is sampled; exactly one `ready`=0 cycle between the two bursts.
- **Reset mid-burst**:
  - Stimulus: assert `resetn` low during beat 3 of an 8-beat write.
  - Required: `resp` drops to 0 in the same cycle; words for beats 1–2 are updated, beats 3–8 are unchanged; a subsequent read is served correctly.

Source files
------------

// File: rtl/cbus_sram_responder.sv
// CBus responder backed by a word array with synchronous write and
// combinational read. Serves single/incrementing-burst reads and
// byte-strobed writes after a fixed number of wait cycles.

package cbus_pkg;

  // Burst length encoded as beats-1
  typedef enum logic [3:0] {
    MLEN1,  MLEN2,  MLEN3,  MLEN4,  MLEN5,  MLEN6,  MLEN7,  MLEN8,
    MLEN9,  MLEN10, MLEN11, MLEN12, MLEN13, MLEN14, MLEN15, MLEN16
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  req,
  output cbus_resp_t resp
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [3:0]    remain;
  logic [3:0]    wait_cnt;

  logic [31:0] mem [WORDS];

  // Address bits outside the word index and the size field carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{req.addr[31:AW+2], req.addr[1:0], req.size};

  // Transaction sequencer: accept, count down the latency, then stream beats
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      remain   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req.valid) begin
            ptr      <= req.addr[AW+1:2];
            remain   <= req.len;
            wait_cnt <= 4'(LATENCY);
            state    <= (LATENCY > 0) ? WAIT : BURST;
          end
        end
        WAIT: begin
          if (!req.valid) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (!req.valid) begin
            state <= IDLE;
          end else begin
            ptr    <= ptr + 1'b1;
            remain <= remain - 4'd1;
            if (remain == 4'd0) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-lane writes on live beats; storage is deliberately never reset
  always_ff @(posedge clk) begin
    if (state == BURST && req.valid && req.is_write) begin
      for (int k = 0; k < 4; k++) begin
        if (req.strobe[k]) begin
          mem[ptr][8*k +: 8] <= req.data[8*k +: 8];
        end
      end
    end
  end

  // Response depends only on registered state and the array contents
  always_comb begin
    resp = '0;
    if (state == BURST) begin
      resp.ready = 1'b1;
      resp.last  = (remain == 4'd0);
      resp.data  = mem[ptr];
    end
  end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Scoreboard bench for cbus_sram_responder: two instances (long latency with
// a large array, zero latency with a tiny array) share clock and reset; one
// is selected at a time and checked beat-by-beat against a reference model.

module tb_cbus_sram_responder;
  import cbus_pkg::*;

  localparam int LAT0   = 2;
  localparam int WORDS0 = 1024;
  localparam int LAT1   = 0;
  localparam int WORDS1 = 16;

  logic       clk;
  logic       resetn;
  logic       sel;
  cbus_req_t  req_drv;
  cbus_req_t  req0;
  cbus_req_t  req1;
  cbus_resp_t resp0;
  cbus_resp_t resp1;
  cbus_resp_t resp_mon;

  typedef struct {
    int          cyc;
    bit          last;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          n_vec;
  int          n_err;
  logic [31:0] refm  [2][1024];
  bit          known [2][1024];
  logic [31:0] wdata [16];
  logic [3:0]  wstrb [16];

  assign req0     = (sel == 1'b0) ? req_drv : '0;
  assign req1     = (sel == 1'b1) ? req_drv : '0;
  assign resp_mon = sel ? resp1 : resp0;

  cbus_sram_responder #(.WORDS(WORDS0), .LATENCY(LAT0)) u_dut0 (
    .clk    (clk),
    .resetn (resetn),
    .req    (req0),
    .resp   (resp0)
  );

  cbus_sram_responder #(.WORDS(WORDS1), .LATENCY(LAT1)) u_dut1 (
    .clk    (clk),
    .resetn (resetn),
    .req    (req1),
    .resp   (resp1)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp expected beats
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a due beat must appear exactly in its cycle, otherwise resp is all zero
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checkOutput("beat_ready", 64'(resp_mon.ready), 64'd1);
      checkOutput("beat_last", 64'(resp_mon.last), 64'(e.last));
      if (e.chk) begin
        checkOutput("beat_data", 64'(resp_mon.data), 64'(e.data));
      end
    end else begin
      checkOutput("idle_resp", 64'(resp_mon), 64'd0);
    end
  end

  // Issue one transaction on the selected instance; called #1 after a rising edge.
  // abort_kind 0: complete, 1: reset during beat abort_beat, 2: drop valid during beat abort_beat.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input int len,
                               input int abort_kind, input int abort_beat, input bit keep_valid);
    int lat;
    int words;
    int start;
    int t0;
    int nbeats;
    int w;
    exp_t e;
    lat    = sel ? LAT1 : LAT0;
    words  = sel ? WORDS1 : WORDS0;
    start  = int'(addr[31:2]) % words;
    t0     = cyc + 1;
    nbeats = (abort_kind == 0) ? len + 1 : (abort_kind == 1 ? abort_beat : abort_beat + 1);

    req_drv.valid    = 1'b1;
    req_drv.is_write = wr;
    req_drv.size     = 2'd2;
    req_drv.addr     = addr;
    req_drv.len      = mlen_t'(len);
    req_drv.strobe   = wstrb[0];
    req_drv.data     = wdata[0];

    for (int i = 0; i < nbeats; i++) begin
      w      = (start + i) % words;
      e.cyc  = t0 + lat + i;
      e.last = (i == len);
      e.data = refm[sel][w];
      e.chk  = known[sel][w];
      sb.push_back(e);
      if (wr && !(abort_kind == 2 && i == abort_beat)) begin
        for (int k = 0; k < 4; k++) begin
          if (wstrb[i][k]) refm[sel][w][8*k +: 8] = wdata[i][8*k +: 8];
        end
        if (wstrb[i] == 4'hF) known[sel][w] = 1'b1;
      end
    end

    repeat (lat + 1) @(posedge clk);
    #1;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
        req_drv.data   = wdata[i];
        req_drv.strobe = wstrb[i];
      end
      if (abort_kind == 1 && i == abort_beat) begin
        resetn        = 1'b0;
        req_drv.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        return;
      end
      if (abort_kind == 2 && i == abort_beat) begin
        req_drv.valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (!keep_valid) req_drv.valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fillData(input logic [31:0] base, input bit rnd);
    for (int i = 0; i < 16; i++) begin
      wdata[i] = rnd ? $urandom : base + 32'(i);
      wstrb[i] = 4'hF;
    end
  endtask

  task automatic randomTraffic(input int count, input int max_word);
    bit          wr;
    bit          b2b;
    int          word;
    int          len;
    logic [31:0] addr;
    for (int n = 0; n < count; n++) begin
      wr   = 1'($urandom_range(0, 1));
      word = $urandom_range(0, max_word);
      addr = ($urandom & 32'hFFFF_F003) | (32'(word) << 2);
      len  = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) begin
        wdata[i] = $urandom;
        wstrb[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
      b2b = (n != count - 1) && ($urandom_range(0, 2) == 0);
      applyStimulus(wr, addr, len, 0, 0, b2b);
      if (!b2b) idleCycles($urandom_range(0, 2));
    end
  endtask

  // Main stimulus sequence
  initial begin
    cyc     = 0;
    n_vec   = 0;
    n_err   = 0;
    sel     = 1'b0;
    req_drv = '0;
    resetn  = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 1024; w++) begin
        refm[s][w]  = '0;
        known[s][w] = 1'b0;
      end
    end

    // Reset held three cycles with a request pending; resp must stay zero
    #2;
    resetn        = 1'b0;
    req_drv.valid = 1'b1;
    req_drv.addr  = 32'h40;
    repeat (3) @(posedge clk);
    #1;
    resetn        = 1'b1;
    req_drv.valid = 1'b0;
    idleCycles(1);

    // Single write then read
    wdata[0] = 32'hDEADBEEF;
    wstrb[0] = 4'hF;
    applyStimulus(1'b1, 32'h10, 0, 0, 0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'h10, 0, 0, 0, 1'b0);

    // Strobed write over a preloaded word
    wdata[0] = 32'h11223344;
    applyStimulus(1'b1, 32'h20, 0, 0, 0, 1'b0);
    wdata[0] = 32'hAABBCCDD;
    wstrb[0] = 4'h5;
    applyStimulus(1'b1, 32'h20, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 32'h20, 0, 0, 0, 1'b0);

    // Sixteen-beat burst wrapping past the top of the array
    fillData(32'h100, 1'b0);
    applyStimulus(1'b1, 32'hFF8, 15, 0, 0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'hFF8, 15, 0, 0, 1'b0);

    randomTraffic(40, 47);

    // Reset during beat 3 of an 8-beat write
    fillData(32'h0, 1'b1);
    applyStimulus(1'b1, 32'h320, 7, 0, 0, 1'b0);
    fillData(32'h0, 1'b1);
    applyStimulus(1'b1, 32'h320, 7, 1, 2, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'h320, 7, 0, 0, 1'b0);
    idleCycles(2);

    // Zero-latency instance: preload, then two back-to-back 4-beat reads
    sel = 1'b1;
    idleCycles(1);
    fillData(32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0, 15, 0, 0, 1'b0);
    applyStimulus(1'b0, 32'h8, 3, 0, 0, 1'b1);
    applyStimulus(1'b0, 32'h14, 3, 0, 0, 1'b0);

    // Valid dropped mid-burst: that beat's write must not land
    fillData(32'h0, 1'b1);
    applyStimulus(1'b1, 32'hC, 5, 2, 3, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 32'h0, 15, 0, 0, 1'b0);

    randomTraffic(40, 15);

    idleCycles(4);
    checkOutput("queue_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
